// File: rtl/pwm_sequencer.sv
// pwm_sequencer: PWM time base with start/stop sequencing and glitch-free shadowed period/duty updates
//   CLK, RST (async, active-high); EN run request
//   CFG_VALID/CFG_READY handshake carrying CFG_PERIOD (period = P+1 cycles) and CFG_DUTY (high cycles)
//   PWM_OUT waveform, CNT counter, PERIOD_END last cycle of period, ACTIVE running or stopping
module pwm_sequencer #(
  parameter int WIDTH      = 4,
  parameter int RST_PERIOD = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CFG_VALID,
  input  logic [WIDTH-1:0] CFG_PERIOD,
  input  logic [WIDTH-1:0] CFG_DUTY,
  output logic             CFG_READY,
  output logic             PWM_OUT,
  output logic [WIDTH-1:0] CNT,
  output logic             PERIOD_END,
  output logic             ACTIVE
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_sh_period;
  logic [WIDTH-1:0] r_sh_duty;
  logic             r_sh_full;
  logic             w_active;
  logic             w_wrap;
  logic             w_capture;
  logic             w_commit;
  assign w_active  = r_state != IDLE;
  assign w_wrap    = w_active && (r_cnt == r_period);
  assign w_capture = CFG_VALID && !r_sh_full;
  // only a shadow filled before this edge may commit, so a capture on a wrap edge waits a full period
  assign w_commit  = r_sh_full && ((r_state == IDLE) || w_wrap);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_period    <= WIDTH'(RST_PERIOD);
      r_duty      <= '0;
      r_sh_period <= '0;
      r_sh_duty   <= '0;
      r_sh_full   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sh_period <= CFG_PERIOD;
        r_sh_duty   <= CFG_DUTY;
        r_sh_full   <= 1'b1;
      end else if (w_commit) begin
        r_period  <= r_sh_period;
        r_duty    <= r_sh_duty;
        r_sh_full <= 1'b0;
      end
      r_cnt   <= ((r_state == IDLE) || w_wrap) ? '0 : r_cnt + 1'b1;
      // EN wins from any state; STOP only falls to IDLE at the wrap edge
      r_state <= EN ? RUN :
                 (r_state == RUN) ? STOP :
                 ((r_state == STOP) && !w_wrap) ? STOP : IDLE;
    end
  end
  assign ACTIVE     = w_active;
  assign CNT        = r_cnt;
  assign CFG_READY  = !r_sh_full;
  assign PWM_OUT    = w_active && (r_cnt < r_duty);
  assign PERIOD_END = w_wrap;
endmodule
